mdu_seq: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit for the E stage; owns the HI/LO registers.

---
 rtl/mdu_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_mdu_seq.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// ---------------------------------------------------------------------------
// mdu_seq -- multi-cycle multiply/divide unit for the E stage.
//
// Owns the HI/LO register pair. mult/multu/div/divu run for a fixed,
// parameterised number of cycles. mthi/mtlo complete in a single cycle.
// An abort input cancels an operation in flight without touching HI/LO.
//
// Handshake: a request is "start & op". It is accepted only on a rising edge
// where the unit is idle and abort is low. While busy every start is ignored.
// The hazard unit must hold the instruction while stall_md is high; stall_md
// covers both the in-flight operation and the cycle a new one is presented.
//
// Ports
//   clk          in   1      clock, rising edge
//   reset        in   1      synchronous, active-high; overrides everything
//   start        in   1      issue op this cycle
//   op           in   3      0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                            5 mthi, 6 mtlo, 7 reserved (no-op)
//   rs_data      in   WIDTH  operand A / mthi-mtlo source
//   rt_data      in   WIDTH  operand B
//   abort        in   1      cancel in-flight op, or drop a same-cycle start
//   out_sel      in   2      1 = HI, 2 = LO, otherwise 0 on rdata
//   rdata        out  WIDTH  combinational read of the registered HI/LO
//   busy         out  1      registered, high while an op is in flight
//   stall_md     out  1      busy | (start & op is mult/multu/div/divu)
//   hi, lo       out  WIDTH  current HI/LO registers
//   o_dbg_state  out  1      FSM state (0 idle, 1 run) for checkers
// ---------------------------------------------------------------------------
module mdu_seq #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             abort,
    input  logic [1:0]       out_sel,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic             stall_md,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             o_dbg_state
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [WIDTH-1:0] ZERO_W = '0;
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;

    // ------------------------------------------------------------------
    // Result datapath, computed from the captured operands. The counter
    // only provides the architectural latency; the result is ready long
    // before it is committed.
    // ------------------------------------------------------------------
    logic             w_is_md;
    logic             w_is_mult;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;
    logic             w_signed_div;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_div_zero;
    logic [WIDTH-1:0] w_div_b;
    logic [WIDTH-1:0] w_q_mag;
    logic [WIDTH-1:0] w_r_mag;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;
    logic             w_res_we;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    assign w_is_mult = (op == OP_MULT) || (op == OP_MULTU);
    assign w_is_md   = w_is_mult || (op == OP_DIV) || (op == OP_DIVU);

    // Sign/zero extension to 2*WIDTH makes the truncated product exact.
    assign w_prod_s = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};
    assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

    // Signed division via magnitudes. INT_MIN / -1 falls out naturally:
    // |INT_MIN| is 2^(WIDTH-1) unsigned, the quotient magnitude is the same
    // pattern, and negating it wraps back to INT_MIN with remainder 0.
    assign w_signed_div = (r_op == OP_DIV);
    assign w_a_neg      = w_signed_div & r_a[WIDTH-1];
    assign w_b_neg      = w_signed_div & r_b[WIDTH-1];
    assign w_mag_a      = w_a_neg ? (ZERO_W - r_a) : r_a;
    assign w_mag_b      = w_b_neg ? (ZERO_W - r_b) : r_b;
    assign w_div_zero   = (r_b == ZERO_W);
    // Keep the divider away from a zero divisor; the result is discarded.
    assign w_div_b      = w_div_zero ? ONE_W : w_mag_b;
    assign w_q_mag      = w_mag_a / w_div_b;
    assign w_r_mag      = w_mag_a % w_div_b;
    assign w_quot       = (w_a_neg ^ w_b_neg) ? (ZERO_W - w_q_mag) : w_q_mag;
    assign w_rem        = w_a_neg ? (ZERO_W - w_r_mag) : w_r_mag;

    always_comb begin
        w_res_we = 1'b0;
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        case (r_op)
            OP_MULT: begin
                w_res_we = 1'b1;
                w_res_hi = w_prod_s[2*WIDTH-1:WIDTH];
                w_res_lo = w_prod_s[WIDTH-1:0];
            end
            OP_MULTU: begin
                w_res_we = 1'b1;
                w_res_hi = w_prod_u[2*WIDTH-1:WIDTH];
                w_res_lo = w_prod_u[WIDTH-1:0];
            end
            OP_DIV, OP_DIVU: begin
                w_res_we = ~w_div_zero;
                w_res_hi = w_rem;
                w_res_lo = w_quot;
            end
            default: begin
                w_res_we = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM. Counter holds the number of busy cycles left including
    // the current one; commit happens on the edge that ends count==1.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_busy <= 1'b0;
                    if (start && !abort) begin
                        if (w_is_md) begin
                            r_a     <= rs_data;
                            r_b     <= rt_data;
                            r_op    <= op;
                            r_count <= w_is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end else if (op == OP_MTHI) begin
                            r_hi <= rs_data;
                        end else if (op == OP_MTLO) begin
                            r_lo <= rs_data;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_count <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_count == CW'(1)) begin
                        if (w_res_we) begin
                            r_hi <= w_res_hi;
                            r_lo <= w_res_lo;
                        end
                        r_state <= ST_IDLE;
                        r_count <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_count <= r_count - CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (out_sel)
            2'd1:    rdata = r_hi;
            2'd2:    rdata = r_lo;
            default: rdata = '0;
        endcase
    end

    assign busy        = r_busy;
    assign stall_md    = r_busy | (start & w_is_md);
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mdu_seq.sv
// ---------------------------------------------------------------------------
// tb_mdu_seq -- self-checking bench for mdu_seq (WIDTH=32, 5/10 cycles).
// Inputs change 1 ns after the rising edge; outputs are sampled there or a
// few ns later, never at the edge. The reference model works on 64-bit
// integers and the HI/LO pair directly.
// ---------------------------------------------------------------------------
module tb_mdu_seq;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        abort;
    logic [1:0]  out_sel;
    logic [31:0] rdata;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        o_dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_seq #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .abort       (abort),
        .out_sel     (out_sel),
        .rdata       (rdata),
        .busy        (busy),
        .stall_md    (stall_md),
        .hi          (hi),
        .lo          (lo),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void model_exec(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            3'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd3: if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
            3'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endfunction

    function automatic int exp_cycles(input logic [2:0] o);
        if (o == 3'd1 || o == 3'd2) return MC;
        if (o == 3'd3 || o == 3'd4) return DC;
        return 0;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            4: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        #1;
    endtask

    // Scrambles the operand buses so a late capture would be visible.
    task automatic release_start();
        start   = 1'b0;
        op      = 3'd0;
        rs_data = $urandom;
        rt_data = $urandom;
    endtask

    // Counts busy cycles (bounded) and how many of them lacked stall_md.
    task automatic wait_idle(output int n, output int stall_miss);
        n = 0;
        stall_miss = 0;
        while (busy === 1'b1 && n < 40) begin
            if (stall_md !== 1'b1) stall_miss++;
            n++;
            step();
        end
    endtask

    task automatic do_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int n, output int stall_miss);
        drive_start(o, a, b);
        step();
        release_start();
        wait_idle(n, stall_miss);
    endtask

    task automatic do_move(input logic [2:0] o, input logic [31:0] a);
        drive_start(o, a, $urandom);
        step();
        release_start();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 3'd0; abort = 1'b0; out_sel = 2'd1;
        rs_data = $urandom; rt_data = $urandom;
        step();
        step();
        reset = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_cmp++; if (lo !== 32'd0) begin n_bad++; $display("FAIL reset_lo: got %h want 0", lo); end
        n_cmp++; if (stall_md !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall_md); end
        n_cmp++; if (o_dbg_state !== 1'b0) begin n_bad++; $display("FAIL reset_state: got %b want 0", o_dbg_state); end
        n_cmp++; if (rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    endtask

    task automatic test_mult();
        int n, sm;
        drive_start(3'd1, 32'hFFFF_FFFF, 32'd2);
        n_cmp++; if (stall_md !== 1'b1) begin n_bad++; $display("FAIL mult_stall_issue: got %b want 1", stall_md); end
        step();
        release_start();
        wait_idle(n, sm);
        model_exec(3'd1, 32'hFFFF_FFFF, 32'd2);
        n_cmp++; if (n != MC) begin n_bad++; $display("FAIL mult_cycles: got %0d want %0d", n, MC); end
        n_cmp++; if (sm != 0) begin n_bad++; $display("FAIL mult_stall_run: %0d cycles without stall, want 0", sm); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL mult_lo: got %h want fffffffe", lo); end
    endtask

    task automatic test_multu_capture();
        int n, sm;
        // release_start changes rs/rt in cycle t+1
        do_md(3'd2, 32'hFFFF_FFFF, 32'd2, n, sm);
        model_exec(3'd2, 32'hFFFF_FFFF, 32'd2);
        n_cmp++; if (n != MC) begin n_bad++; $display("FAIL multu_cycles: got %0d want %0d", n, MC); end
        n_cmp++; if (hi !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_hi: got %h want 00000001", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_lo: got %h want fffffffe", lo); end
    endtask

    task automatic test_div();
        int n, sm;
        do_md(3'd3, 32'hFFFF_FFF9, 32'd2, n, sm);
        model_exec(3'd3, 32'hFFFF_FFF9, 32'd2);
        n_cmp++; if (n != DC) begin n_bad++; $display("FAIL div_cycles: got %0d want %0d", n, DC); end
        n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_hi: got %h want ffffffff", hi); end
        do_move(3'd5, 32'h1234); model_exec(3'd5, 32'h1234, 0);
        do_move(3'd6, 32'h1234); model_exec(3'd6, 32'h1234, 0);
        do_md(3'd4, 32'd7, 32'd0, n, sm);
        model_exec(3'd4, 32'd7, 32'd0);
        n_cmp++; if (n != DC) begin n_bad++; $display("FAIL divu0_cycles: got %0d want %0d", n, DC); end
        n_cmp++; if (hi !== 32'h1234 || lo !== 32'h1234) begin n_bad++; $display("FAIL divu0_hilo: got %h/%h want 00001234/00001234", hi, lo); end
        do_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, n, sm);
        model_exec(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        n_cmp++; if (lo !== 32'h8000_0000 || hi !== 32'd0) begin n_bad++; $display("FAIL div_intmin: got %h/%h want 00000000/80000000", hi, lo); end
    endtask

    task automatic test_moves();
        int n, sm;
        drive_start(3'd5, 32'hAAAA, 32'd0);
        n_cmp++; if (stall_md !== 1'b0) begin n_bad++; $display("FAIL mthi_stall: got %b want 0", stall_md); end
        step();
        op = 3'd6; rs_data = 32'h5555;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mthi_busy: got %b want 0", busy); end
        step();
        release_start();
        model_exec(3'd5, 32'hAAAA, 0);
        model_exec(3'd6, 32'h5555, 0);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mtlo_busy: got %b want 0", busy); end
        n_cmp++; if (hi !== 32'hAAAA || lo !== 32'h5555) begin n_bad++; $display("FAIL moves_hilo: got %h/%h want 0000aaaa/00005555", hi, lo); end
        // starts while busy: mthi and a div are both ignored
        drive_start(3'd2, 32'd123456, 32'd789);
        step();
        drive_start(3'd5, 32'hDEAD_BEEF, 32'd0);
        step();
        drive_start(3'd3, 32'd100, 32'd3);
        step();
        release_start();
        wait_idle(n, sm);
        model_exec(3'd2, 32'd123456, 32'd789);
        n_cmp++; if (n + 2 != MC) begin n_bad++; $display("FAIL busy_start_cycles: got %0d want %0d", n + 2, MC); end
        n_cmp++; if (hi !== m_hi || lo !== m_lo) begin n_bad++; $display("FAIL busy_start_hilo: got %h/%h want %h/%h", hi, lo, m_hi, m_lo); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_start_idle: got %b want 0", busy); end
    endtask

    task automatic test_abort();
        do_move(3'd5, 32'h1111_2222); model_exec(3'd5, 32'h1111_2222, 0);
        do_move(3'd6, 32'h3333_4444); model_exec(3'd6, 32'h3333_4444, 0);
        // abort in cycle 3 of a div
        drive_start(3'd3, 32'd100, 32'd7);
        step();
        release_start();
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        repeat (DC + 2) step();
        n_cmp++; if (hi !== m_hi || lo !== m_lo) begin n_bad++; $display("FAIL abort_hilo: got %h/%h want %h/%h", hi, lo, m_hi, m_lo); end
        // abort on the final busy cycle
        drive_start(3'd1, 32'd9, 32'd9);
        step();
        release_start();
        repeat (MC - 1) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++; if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin n_bad++; $display("FAIL abort_last: got busy=%b %h/%h want 0 %h/%h", busy, hi, lo, m_hi, m_lo); end
        // abort with start in the same cycle drops the start
        drive_start(3'd1, 32'd5, 32'd6);
        abort = 1'b1;
        step();
        drive_start(3'd5, 32'hFFFF_0000, 32'd0);
        step();
        abort = 1'b0;
        release_start();
        n_cmp++; if (busy !== 1'b0 || hi !== m_hi) begin n_bad++; $display("FAIL abort_start: got busy=%b hi=%h want 0 %h", busy, hi, m_hi); end
        // reset in the middle of a mult
        drive_start(3'd1, 32'd1000, 32'd1000);
        step();
        release_start();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        n_cmp++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin n_bad++; $display("FAIL reset_mid: got busy=%b %h/%h want 0 0/0", busy, hi, lo); end
    endtask

    task automatic test_rdata_stall();
        int n, sm;
        do_move(3'd5, 32'h0BAD_F00D); model_exec(3'd5, 32'h0BAD_F00D, 0);
        do_move(3'd6, 32'hCAFE_0001); model_exec(3'd6, 32'hCAFE_0001, 0);
        out_sel = 2'd2;
        drive_start(3'd1, 32'd3, 32'd4);
        n_cmp++; if (rdata !== m_lo) begin n_bad++; $display("FAIL rd_issue_lo: got %h want %h", rdata, m_lo); end
        n_cmp++; if (stall_md !== 1'b1) begin n_bad++; $display("FAIL rd_issue_stall: got %b want 1", stall_md); end
        out_sel = 2'd1;
        #1;
        n_cmp++; if (rdata !== m_hi) begin n_bad++; $display("FAIL rd_issue_hi: got %h want %h", rdata, m_hi); end
        step();
        release_start();
        out_sel = 2'd2;
        #1;
        n_cmp++; if (rdata !== m_lo) begin n_bad++; $display("FAIL rd_no_forward: got %h want %h", rdata, m_lo); end
        out_sel = 2'd3;
        #1;
        n_cmp++; if (rdata !== 32'd0) begin n_bad++; $display("FAIL rd_sel3: got %h want 0", rdata); end
        wait_idle(n, sm);
        model_exec(3'd1, 32'd3, 32'd4);
        n_cmp++; if (n != MC || sm != 0) begin n_bad++; $display("FAIL rd_stall_run: got %0d cycles %0d misses want %0d 0", n, sm, MC); end
        n_cmp++; if (stall_md !== 1'b0) begin n_bad++; $display("FAIL rd_stall_done: got %b want 0", stall_md); end
        out_sel = 2'd2;
        #1;
        n_cmp++; if (rdata !== 32'd12) begin n_bad++; $display("FAIL rd_result_lo: got %h want 0000000c", rdata); end
        out_sel = 2'd0;
    endtask

    // Random ops issued back to back: each starts in the first idle cycle.
    task automatic test_back_to_back();
        int n, sm;
        logic [2:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            drive_start(o, a, b);
            n_cmp++; if (stall_md !== (exp_cycles(o) != 0)) begin n_bad++; $display("FAIL rnd_stall[%0d]: op %0d got %b", i, o, stall_md); end
            step();
            release_start();
            wait_idle(n, sm);
            model_exec(o, a, b);
            n_cmp++; if (n != exp_cycles(o) || sm != 0) begin n_bad++; $display("FAIL rnd_cycles[%0d]: op %0d got %0d (%0d misses) want %0d", i, o, n, sm, exp_cycles(o)); end
            n_cmp++; if (hi !== m_hi || lo !== m_lo) begin n_bad++; $display("FAIL rnd_hilo[%0d]: op %0d a=%h b=%h got %h/%h want %h/%h", i, o, a, b, hi, lo, m_hi, m_lo); end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_mult();
        test_multu_capture();
        test_div();
        test_moves();
        test_abort();
        test_rdata_stall();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
